// File: rtl/apb2axi_cmd_regfile.sv
// apb2axi_cmd_regfile: APB register file staging AXI command descriptors into a drainable FIFO
module apb2axi_cmd_regfile #(
  parameter int AXI_ADDR_W = 64,
  parameter int APB_ADDR_W = 16,
  parameter int APB_DATA_W = 32,
  parameter int CMD_DEPTH = 4,
  parameter int ID_W = 4
) (
  input  logic                            pclk,
  input  logic                            presetn,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [APB_ADDR_W-1:0]           paddr,
  input  logic [APB_DATA_W-1:0]           pwdata,
  output logic [APB_DATA_W-1:0]           prdata,
  output logic                            pready,
  output logic                            pslverr,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [AXI_ADDR_W-1:0]           cmd_addr,
  output logic [7:0]                      cmd_len,
  output logic [2:0]                      cmd_size,
  output logic [ID_W-1:0]                 cmd_id,
  output logic                            cmd_is_write,
  output logic [$clog2(CMD_DEPTH+1)-1:0]  cmd_count,
  output logic                            ovf_irq
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = $clog2(CMD_DEPTH + 1);
  logic access, wr_acc, rd_acc, full, empty, commit, push, reject, pop, ovf;
  logic [2:0] sel, size_q;
  logic [31:0] addr_lo, addr_hi, cmd_reg, status, rdata;
  logic [7:0] len_q;
  logic [ID_W-1:0] id_q;
  logic wr_q;
  logic [63:0] stage_addr;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [AXI_ADDR_W-1:0] addr_mem [CMD_DEPTH];
  logic [7:0] len_mem [CMD_DEPTH];
  logic [2:0] size_mem [CMD_DEPTH];
  logic [ID_W-1:0] id_mem [CMD_DEPTH];
  logic wr_mem [CMD_DEPTH];
  logic unused_paddr;
  assign unused_paddr = ^{paddr[APB_ADDR_W-1:5], paddr[1:0]};
  assign sel = paddr[4:2];
  assign access = psel & penable & presetn;
  assign wr_acc = access & pwrite;
  assign rd_acc = access & ~pwrite;
  assign full = count == CW'(CMD_DEPTH);
  assign empty = count == '0;
  assign commit = wr_acc & (sel == 3'd3);
  assign push = commit & ~full;
  assign reject = commit & full;
  assign pop = cmd_valid & cmd_ready;
  assign stage_addr = {addr_hi, addr_lo};
  assign cmd_reg = {wr_q, {(19 - ID_W){1'b0}}, id_q, 1'b0, size_q, len_q};
  assign status = {15'd0, ovf, 8'(count), 6'd0, empty, full};
  always_comb begin
    rdata = '0;
    case (sel)
      3'd0: rdata = addr_lo;
      3'd1: rdata = addr_hi;
      3'd2: rdata = cmd_reg;
      3'd4: rdata = status;
      default: rdata = '0;
    endcase
  end
  assign prdata = rd_acc ? rdata : '0;
  assign pready = 1'b1;
  assign pslverr = access & ((sel >= 3'd6) | (pwrite & (sel == 3'd4)) | reject);
  assign cmd_valid = ~empty;
  assign cmd_addr = empty ? '0 : addr_mem[rd_ptr];
  assign cmd_len = empty ? '0 : len_mem[rd_ptr];
  assign cmd_size = empty ? '0 : size_mem[rd_ptr];
  assign cmd_id = empty ? '0 : id_mem[rd_ptr];
  assign cmd_is_write = empty ? 1'b0 : wr_mem[rd_ptr];
  assign cmd_count = count;
  assign ovf_irq = ovf;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_lo <= '0;
      addr_hi <= '0;
      len_q <= '0;
      size_q <= '0;
      id_q <= '0;
      wr_q <= 1'b0;
      ovf <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc && sel == 3'd0) addr_lo <= pwdata;
      if (wr_acc && sel == 3'd1) addr_hi <= pwdata;
      if (wr_acc && sel == 3'd2) begin
        len_q <= pwdata[7:0];
        size_q <= pwdata[10:8];
        id_q <= pwdata[12 +: ID_W];
        wr_q <= pwdata[31];
      end
      if (reject) ovf <= 1'b1;
      else if (wr_acc && sel == 3'd5 && pwdata[16]) ovf <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge pclk) begin
    if (push) begin
      addr_mem[wr_ptr] <= stage_addr[AXI_ADDR_W-1:0];
      len_mem[wr_ptr] <= len_q;
      size_mem[wr_ptr] <= size_q;
      id_mem[wr_ptr] <= id_q;
      wr_mem[wr_ptr] <= wr_q;
    end
  end
endmodule

// File: doc/apb2axi_cmd_regfile.md
Name: apb2axi_cmd_regfile

Overview:
APB-slave command register file for the APB-to-AXI gateway.
- Software stages address, length, size, ID and direction in registers, then writes a dedicated COMMIT register to push a complete command descriptor into an internal FIFO of CMD_DEPTH entries.
- The FIFO drains toward the directory over a valid/ready interface.
- Adds register readback, status, error responses and overflow tracking.

Parameters:
- AXI_ADDR_W, 64, AXI address width (ADDR_HI supplies bits above 32).
- APB_ADDR_W, 16, APB address width.
- APB_DATA_W, 32, APB data width (fixed 32 for this block).
- CMD_DEPTH, 4, command FIFO entries (power of two, ≥2).
- ID_W, 4, AXI ID width (≤4).

Ports:
- pclk  in  1  clock
- presetn  in  1  reset, asynchronous, active-low
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  APB_ADDR_W  APB address; decode uses paddr[4:2]
- pwdata  in  APB_DATA_W  write data
- prdata  out  APB_DATA_W  read data
- pready  out  1  always 1
- pslverr  out  1  error response
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  consumer accept
- cmd_addr  out  AXI_ADDR_W  head address
- cmd_len  out  8  head AXI len
- cmd_size  out  3  head AXI size
- cmd_id  out  ID_W  head AXI ID
- cmd_is_write  out  1  head direction
- cmd_count  out  $clog2(CMD_DEPTH+1)  FIFO occupancy
- ovf_irq  out  1  level copy of sticky overflow bit

Behaviour:
- Access cycle = psel & penable. pready = 1, so every transfer completes in its access cycle. Register side effects take place at the clock edge ending that cycle.
- Register map (paddr[4:2]):
  - 0 ADDR_LO (RW)
  - 1 ADDR_HI (RW)
  - 2 CMD (RW): [7:0] len, [10:8] size, [12+ID_W-1:12] id, [31] is_write; other bits read 0
  - 3 COMMIT (WO, reads 0)
  - 4 STATUS (RO): [0] full, [1] empty, [15:8] count, [16] overflow
  - 5 STATUS_CLR (W1C): bit16 clears overflow
- Offsets 6–7 return pslverr=1 with no side effect and prdata=0. A write to STATUS also returns pslverr=1.
- prdata is combinational from current register state during the access cycle. It is 0 outside access cycles and when pwrite=1.
- COMMIT write with FIFO not full pushes {ADDR_HI,ADDR_LO truncated to AXI_ADDR_W, len, size, id, is_write} and returns pslverr=0. pwdata is ignored.
- COMMIT write with FIFO full does not push, returns pslverr=1 and sets overflow. Full is sampled before any same-cycle pop, so a simultaneous pop does not rescue the push.
- Staging registers are not cleared by commit. Repeated COMMIT writes push identical descriptors.
- FIFO:
  - Pop occurs when cmd_valid & cmd_ready.
  - cmd_valid = ~empty; cmd_* = head entry.
  - A push into an empty FIFO makes cmd_valid rise on the next cycle (1-cycle latency, no bypass).
  - Simultaneous push (non-full) and pop leaves count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
  - count ranges 0..CMD_DEPTH.
- overflow: sticky. Set by a rejected commit; cleared only by a STATUS_CLR write with bit16=1. If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-transfer or while the FIFO is non-empty) forces:
  - all staging registers to 0
  - FIFO empty, cmd_valid=0, cmd_count=0
  - overflow=0, ovf_irq=0
  - pslverr=0, prdata=0
  - cmd_* = 0 (the head entry is masked to 0 when empty)

Test Plan:
- Write ADDR_LO=0x1000, ADDR_HI=0x1, CMD=0x8000_0203, COMMIT, cmd_ready=0 → next cycle cmd_valid=1, cmd_addr=0x1_0000_1000, len=3, size=2, is_write=1, count=1. Readback of the three registers matches the written values.
- With cmd_ready=0, perform 4 commits (CMD_DEPTH=4) then a 5th → 5th returns pslverr=1; STATUS=0x0001_0401; ovf_irq=1. Write STATUS_CLR=0x1_0000 → overflow=0.
- FIFO full, cmd_ready=1 held during a COMMIT → commit rejected (pslverr=1), count goes 4→3; subsequent pops drain in FIFO order.
- Push/pop wrap: 10 commits with distinct ADDR_LO values, cmd_ready=1 continuously → all 10 emerge in order, count never exceeds 1, no overflow.
- Access to offset 0x18 read and write, plus a write to STATUS → pslverr=1, prdata=0, no register change.
- Assert presetn low asynchronously mid-access with count=3 → all outputs 0 before the next pclk edge; after release, empty=1 and registers read 0.
